// File: rtl/soundweb_pkg.sv
// Shared Soundweb constants: framing bytes, transaction result codes and the
// transmit sequencer state encoding. Used by the encoder, the transmit
// sequencer and the receive decoder.
package soundweb_pkg;

    // Framing and control bytes
    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] ESC = 8'h1B;

    // Transaction result codes
    localparam logic [1:0] RES_ACK       = 2'b00;
    localparam logic [1:0] RES_NAK       = 2'b01;
    localparam logic [1:0] RES_TIMEOUT   = 2'b10;
    localparam logic [1:0] RES_MALFORMED = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SEND,
        WAIT_ACK,
        DONE
    } sw_state_e;

    // Saturate a transmission count to the 2-bit reporting range
    function automatic logic [1:0] sat_tries(input logic [7:0] tries);
        return (tries > 8'd3) ? 2'd3 : tries[1:0];
    endfunction

endpackage

// File: rtl/soundweb_ack_timer.sv
// Reply timeout counter. Counts enabled cycles from zero and flags the cycle
// in which the count reaches ACK_TIMEOUT-1; it then holds until cleared.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force the count to zero (wins over enable)
//   enable     : advance the count by one this cycle
//   expired_c  : count has reached ACK_TIMEOUT-1 (combinational)
module soundweb_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [TW-1:0] count_q;

    assign expired_c = (count_q == TW'(ACK_TIMEOUT - 1));

    // Stop at the terminal value so the counter never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired_c) begin
            count_q <= count_q + TW'(1);
        end
    end

endmodule

// File: rtl/soundweb_tx_sequencer.sv
// Soundweb transmit sequencer. Latches one escaped frame from the encoder,
// streams it to the UART transmitter byte by byte until the first ETX after
// byte 0, then waits for ACK/NAK, resending on NAK or timeout.
//   clk, rst_n        : clock, synchronous active-low reset
//   packet_in, start  : frame bytes (byte k at [8k+7:8k]) and latch request
//   busy, done        : transaction in progress / one-cycle completion pulse
//   result, tries_used: outcome code and transmission count, valid with done
//   tx_data, tx_valid, tx_ready : byte stream to the UART transmitter
//   rx_data, rx_valid : reply bytes from the UART receiver
module soundweb_tx_sequencer
    import soundweb_pkg::*;
#(
    parameter int unsigned PACKET_BYTES = 29,
    parameter int unsigned ACK_TIMEOUT  = 50000,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned ACK_ENABLE   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [8*PACKET_BYTES-1:0] packet_in,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                result,
    output logic [1:0]                tries_used,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid
);

    localparam int unsigned IW  = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
    localparam int unsigned TRW = $clog2(MAX_TRIES + 1);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(PACKET_BYTES - 1);
    localparam logic [TRW-1:0] TRIES_MAX = TRW'(MAX_TRIES);

    sw_state_e      state_q;
    logic [7:0]     pkt_buf_q [PACKET_BYTES];
    logic [IW-1:0]  index_q;
    logic [IW-1:0]  index_next_c;
    logic [TRW-1:0] tries_q;
    logic           timer_clear_c;
    logic           timer_en_c;
    logic           timer_expired_c;
    logic           rx_ack_c;
    logic           rx_nak_c;

    assign index_next_c  = index_q + IW'(1);
    assign timer_clear_c = (state_q != WAIT_ACK);
    assign timer_en_c    = (state_q == WAIT_ACK);
    assign rx_ack_c      = rx_valid && (rx_data == ACK);
    assign rx_nak_c      = rx_valid && (rx_data == NAK);

    // Reply timeout; held cleared outside WAIT_ACK so every wait starts at zero
    soundweb_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear_c),
        .enable    (timer_en_c),
        .expired_c (timer_expired_c)
    );

    // Frame buffer: loaded only on an accepted start, never reset
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            for (int k = 0; k < int'(PACKET_BYTES); k++) begin
                pkt_buf_q[k] <= packet_in[8*k +: 8];
            end
        end
    end

    // Transaction sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            result     <= RES_ACK;
            tries_used <= '0;
            index_q    <= '0;
            tries_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        tries_q    <= TRW'(1);
                        index_q    <= '0;
                        result     <= RES_ACK;
                        tries_used <= '0;
                        state_q    <= CHECK;
                    end
                end

                CHECK: begin
                    if (pkt_buf_q[0] != STX) begin
                        tries_q    <= '0;
                        done       <= 1'b1;
                        result     <= RES_MALFORMED;
                        tries_used <= 2'd0;
                        state_q    <= DONE;
                    end else begin
                        tx_valid <= 1'b1;
                        tx_data  <= pkt_buf_q[0];
                        state_q  <= SEND;
                    end
                end

                // tx_valid is always high here, so tx_ready alone marks a transfer.
                // Body 0x03 bytes arrive escaped, so the first raw ETX past byte 0 ends the frame.
                SEND: begin
                    if (tx_ready) begin
                        if (tx_data == ETX && index_q != '0) begin
                            tx_valid <= 1'b0;
                            if (ACK_ENABLE != 0) begin
                                state_q <= WAIT_ACK;
                            end else begin
                                done       <= 1'b1;
                                result     <= RES_ACK;
                                tries_used <= sat_tries(8'(tries_q));
                                state_q    <= DONE;
                            end
                        end else if (index_q == LAST_IDX) begin
                            tx_valid   <= 1'b0;
                            done       <= 1'b1;
                            result     <= RES_MALFORMED;
                            tries_used <= sat_tries(8'(tries_q));
                            state_q    <= DONE;
                        end else begin
                            index_q <= index_next_c;
                            tx_data <= pkt_buf_q[index_next_c];
                        end
                    end
                end

                // ACK beats an expiring timer; NAK and expiry share the retry path
                WAIT_ACK: begin
                    if (rx_ack_c) begin
                        done       <= 1'b1;
                        result     <= RES_ACK;
                        tries_used <= sat_tries(8'(tries_q));
                        state_q    <= DONE;
                    end else if (rx_nak_c || timer_expired_c) begin
                        if (tries_q < TRIES_MAX) begin
                            tries_q  <= tries_q + TRW'(1);
                            index_q  <= '0;
                            tx_valid <= 1'b1;
                            tx_data  <= pkt_buf_q[0];
                            state_q  <= SEND;
                        end else begin
                            done       <= 1'b1;
                            result     <= rx_nak_c ? RES_NAK : RES_TIMEOUT;
                            tries_used <= sat_tries(8'(tries_q));
                            state_q    <= DONE;
                        end
                    end
                end

                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/soundweb_tx_sequencer.md
Name: soundweb_tx_sequencer

Overview:
- Downstream of the Soundweb packet encoder.
- Latches one encoded, escaped packet of up to 29 bytes and streams it byte by byte to the UART transmitter over a valid/ready handshake.
- Then waits for the device's ACK (0x06) or NAK (0x15) on the UART receive path, retrying on NAK or timeout.
- Frame length is not supplied; the frame ends at the first 0x03 (ETX) after byte 0. This is valid because every 0x03 in the body has already been escaped.

Parameters:
- PACKET_BYTES, 29: maximum frame length in bytes, including STX and ETX.
- ACK_TIMEOUT, 50000: cycles to wait for ACK/NAK after the ETX handshake.
- MAX_TRIES, 3: total transmissions attempted, including the first; must be at least 1.
- ACK_ENABLE, 1: when 0, the block skips WAIT_ACK and reports success right after ETX is sent.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: synchronous active-low reset.
- packet_in, input, 8*PACKET_BYTES: encoder bytes. Byte k is bits [8k+7:8k]; byte 0 is STX.
- start, input, 1: single-cycle request to latch packet_in and begin transmission.
- busy, output, 1: high from the start-accept cycle until the done cycle inclusive.
- done, output, 1: one-cycle pulse when the transaction ends.
- result, output, 2: valid when done is high. 00 = ACK, 01 = NAK retries exhausted, 10 = timeout retries exhausted, 11 = malformed frame.
- tries_used, output, 2: number of transmissions made; valid when done is high.
- tx_data, output, 8: byte to the UART transmitter.
- tx_valid, output, 1: tx_data is valid.
- tx_ready, input, 1: UART transmitter accepts the byte; a transfer occurs when tx_valid and tx_ready are both high.
- rx_data, input, 8: byte from the UART receiver.
- rx_valid, input, 1: one-cycle strobe qualifying rx_data.

Behaviour:
- Reset: registered at the next clk edge with rst_n=0. On reset:
  - state = IDLE.
  - busy, done, tx_valid = 0.
  - tx_data, result, tries_used = 0.
  - Byte index, retry count and timeout counter = 0.
  - Packet buffer contents are don't-care.
- Reset mid-operation aborts immediately: tx_valid drops, no done pulse is issued, and any partial frame is abandoned.
- IDLE:
  - start=1 latches packet_in into the buffer, sets busy=1, tries=1, index=0, and moves to CHECK.
  - start while busy=1 is ignored, with no effect on the buffer.
- CHECK (1 cycle):
  - If buffer byte 0 is not 0x02 → DONE with result=11 and tries_used=0.
  - Otherwise → SEND.
  - Start-to-first-tx_valid latency is therefore 2 cycles.
- SEND:
  - tx_valid=1 and tx_data=buffer[index].
  - tx_data is held stable while tx_ready=0.
  - On a transfer of a byte equal to 0x03 with index>0:
    - If ACK_ENABLE=1 → WAIT_ACK, with the timeout counter cleared.
    - If ACK_ENABLE=0 → DONE with result=00.
  - On a transfer of any other byte with index < PACKET_BYTES-1: index is incremented and the next byte is presented in the next cycle. Back-to-back transfers at one byte per cycle are supported.
  - On a transfer at index = PACKET_BYTES-1 that is not ETX → DONE with result=11.
  - rx_valid is ignored in SEND, because the block does not accept replies to a frame still in flight.
- WAIT_ACK:
  - tx_valid=0; the timeout counter increments once per cycle.
  - rx_valid with 0x06 → DONE with result=00.
  - rx_valid with 0x15, or counter reaching ACK_TIMEOUT-1:
    - If tries < MAX_TRIES: tries is incremented, index=0, and the state goes to SEND. The resend uses the latched buffer.
    - Otherwise → DONE with result=01 (NAK) or 10 (timeout).
  - Other rx bytes are ignored and do not reset the counter.
  - If ACK arrives in the same cycle the timeout expires, ACK wins.
  - If NAK arrives in the same cycle the timeout expires, NAK wins.
- DONE (1 cycle):
  - done=1, busy=1, result and tries_used are valid. tries_used = tries saturated to 3.
  - Next state is IDLE. A start arriving in the DONE cycle is ignored.
  - result and tries_used hold their values until the next start.
- Width rules:
  - Index width is clog2(PACKET_BYTES).
  - Timeout counter width is clog2(ACK_TIMEOUT).
  - Tries counter width is clog2(MAX_TRIES+1).
  - No counter ever wraps: each is compared and cleared before it can overflow.

Decomposition:
- Shared package soundweb_pkg holds:
  - Byte constants: STX 0x02, ETX 0x03, ACK 0x06, NAK 0x15, ESC 0x1B.
  - The result encodings: RES_ACK, RES_NAK, RES_TIMEOUT, RES_MALFORMED.
  - The state enum: IDLE, CHECK, SEND, WAIT_ACK, DONE.
- These constants are shared with the encoder and with the future receive decoder.
- One sub-module is natural: soundweb_ack_timer, a timeout counter with clear, enable and expired outputs.

Test Plan:
- Frame 02 8D 1E 19 03 followed by zeros, tx_ready=1 throughout, rx 06 arriving 10 cycles after ETX → 5 bytes emitted on consecutive cycles starting 2 cycles after start; done with result=00 and tries_used=1.
- Same frame with tx_ready toggling 1,0,0,1 → tx_data is held stable during the stall and the byte order is unchanged.
- Frame containing an escaped body 02 88 1B 83 03 → the block stops only at index 4; the 0x83 is not mistaken for ETX. Also confirm that a 0x03 at index 0 is never treated as ETX.
- Replies NAK, then timeout, then ACK with MAX_TRIES=3 → frame sent 3 times; done with result=00 and tries_used=3. Replies NAK, NAK, NAK → result=01.
- Byte 0 = 0x55 → done 2 cycles after start with result=11 and no tx_valid. 29 bytes with no ETX → all 29 bytes are sent, then done with result=11.
- rst_n=0 during SEND at index 3 → the next cycle shows tx_valid=0 and busy=0 with no done pulse; a following start transmits the full frame again.
